// File: rtl/ltc2308_scan_ctrl.sv
// ltc2308_scan_ctrl
// Round-robin scan master for the LTC2308 12-bit SAR ADC.
// Each frame: CONVST pulse, conversion wait, 12-period SCK burst that
// shifts the previous conversion in on adc_sdo while shifting the next
// channel's 6-bit config word out on adc_sdi, then a one-cycle GAP.
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   enable            level, 1 = scan continuously
//   adc_convst        ADC conversion start
//   adc_sck           ADC serial clock, idle low
//   adc_sdi           ADC config data, MSB first
//   adc_sdo           ADC result data, MSB first
//   busy              1 whenever the FSM is not idle
//   data_valid        one-cycle result strobe (in GAP)
//   data_ch, data     channel tag and 12-bit result, held until next valid
module ltc2308_scan_ctrl #(
  parameter int CH_NUM         = 8,
  parameter int CLK_DIV        = 2,
  parameter int TCONVST_CYCLES = 2,
  parameter int TCONV_CYCLES   = 80,
  parameter int UNI            = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic        adc_convst,
  output logic        adc_sck,
  output logic        adc_sdi,
  input  logic        adc_sdo,
  output logic        busy,
  output logic        data_valid,
  output logic [2:0]  data_ch,
  output logic [11:0] data
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CONVST = 3'd1;
  localparam logic [2:0] S_CONV   = 3'd2;
  localparam logic [2:0] S_SHIFT  = 3'd3;
  localparam logic [2:0] S_GAP    = 3'd4;

  localparam logic [15:0] CONVST_LAST = 16'(TCONVST_CYCLES - 1);
  localparam logic [15:0] CONV_LAST   = 16'(TCONV_CYCLES - 1);
  localparam logic [15:0] DIV_LAST    = 16'(CLK_DIV - 1);
  localparam logic [2:0]  CH_LAST     = 3'(CH_NUM - 1);
  localparam logic        UNI_BIT     = (UNI != 0);

  logic [2:0]  state;
  logic [15:0] cnt;
  logic        hi;        // current SCK phase inside SHIFT
  logic [3:0]  bit_idx;   // SCK period 0..11
  logic [2:0]  ptr;       // channel whose config word goes out this frame
  logic [2:0]  prev_ch;   // channel whose conversion is read this frame
  logic        first;     // current frame's read-back is a dummy
  logic [11:0] shreg;
  logic [11:0] sh_next;
  logic [7:0]  cfg;
  logic        sample;

  always_comb begin
    // Config word padded to 8 bits so the MSB-first index never leaves range.
    cfg     = {1'b1, ptr[0], ptr[2:1], UNI_BIT, 1'b0, 2'b00};
    sample  = (state == S_SHIFT) && hi && (cnt == 16'd0);
    // sh_next lets the GAP transition capture the 12th bit even when the
    // sample cycle and the last high cycle coincide (CLK_DIV = 1).
    sh_next = sample ? {shreg[10:0], adc_sdo} : shreg;
  end

  assign adc_convst = (state == S_CONVST);
  assign adc_sck    = (state == S_SHIFT) && hi;
  assign adc_sdi    = (state == S_SHIFT) && (bit_idx < 4'd6) &&
                      cfg[3'd7 - bit_idx[2:0]];
  assign busy       = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      hi         <= 1'b0;
      bit_idx    <= '0;
      ptr        <= '0;
      prev_ch    <= '0;
      first      <= 1'b1;
      shreg      <= '0;
      data_valid <= 1'b0;
      data       <= '0;
      data_ch    <= '0;
    end else begin
      data_valid <= 1'b0;
      shreg      <= sh_next;
      case (state)
        S_IDLE: begin
          first <= 1'b1;
          cnt   <= '0;
          if (enable) state <= S_CONVST;
        end
        S_CONVST: begin
          if (cnt == CONVST_LAST) begin
            cnt   <= '0;
            state <= S_CONV;
          end else cnt <= cnt + 16'd1;
        end
        S_CONV: begin
          hi      <= 1'b0;
          bit_idx <= '0;
          if (cnt == CONV_LAST) begin
            cnt   <= '0;
            state <= S_SHIFT;
          end else cnt <= cnt + 16'd1;
        end
        S_SHIFT: begin
          if (cnt == DIV_LAST) begin
            cnt <= '0;
            hi  <= ~hi;
            if (hi) begin
              if (bit_idx == 4'd11) begin
                state   <= S_GAP;
                prev_ch <= ptr;
                ptr     <= (ptr == CH_LAST) ? 3'd0 : ptr + 3'd1;
                first   <= 1'b0;
                if (!first) begin
                  data_valid <= 1'b1;
                  data       <= sh_next;
                  data_ch    <= prev_ch;
                end
              end else bit_idx <= bit_idx + 4'd1;
            end
          end else cnt <= cnt + 16'd1;
        end
        S_GAP:   state <= enable ? S_CONVST : S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/ltc2308_scan_ctrl.md
Name: ltc2308_scan_ctrl

Overview:
Synthesizable master controller for the LTC2308 12-bit SAR ADC on the DE10-Nano. It scans channels 0..CH_NUM-1 in round-robin order. For each frame it generates CONVST, waits out the conversion, then runs a 12-bit SCK burst that shifts in the result on adc_sdo while shifting out the 6-bit config word for the next conversion on adc_sdi. Results are tagged with their channel and emitted as a one-cycle valid pulse to fabric logic.

Parameters:
CH_NUM, 8, number of scanned single-ended channels, 1..8.
CLK_DIV, 2, SCK half-period in clk cycles, >=1.
TCONVST_CYCLES, 2, adc_convst high width in clk cycles, >=1.
TCONV_CYCLES, 80, conversion wait in clk cycles (1.6 us at 50 MHz).
UNI, 1, value of the config UNI bit (1 = unipolar, 0 = bipolar).

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
enable  input  1  level; 1 = scan continuously
adc_convst  output  1  ADC conversion start
adc_sck  output  1  ADC serial clock, idle low
adc_sdi  output  1  ADC config data, MSB first
adc_sdo  input  1  ADC result data, MSB first
busy  output  1  1 whenever the FSM is not in IDLE
data_valid  output  1  one-cycle strobe, result valid
data_ch  output  3  channel of the current data
data  output  12  conversion result

Behaviour:
- Reset (asynchronous, immediate): all outputs 0, FSM = IDLE, channel pointer = 0, first-frame flag = 1.
- FSM states: IDLE -> CONVST -> CONV -> SHIFT -> GAP -> CONVST (or IDLE).
- IDLE: all outputs 0. When enable=1, go to CONVST next cycle.
- CONVST: adc_convst=1 for exactly TCONVST_CYCLES cycles, then CONV.
- CONV: adc_convst=0 and adc_sck=0 for TCONV_CYCLES cycles, then SHIFT.
- SHIFT: exactly 12 SCK periods. Each period is CLK_DIV cycles low followed by CLK_DIV cycles high.
  - adc_sdi changes only in the first cycle of each low phase.
  - adc_sdo is sampled into a 12-bit shift register, MSB first, in the cycle adc_sck goes high.
  - Bits 1..6 carry the config word, bits 7..12 drive adc_sdi=0.
  - After the 12th high phase, go to GAP.
- GAP: 1 cycle, adc_sck=0.
  - If enable=1, go to CONVST; otherwise go to IDLE.
  - An enable drop before GAP never truncates a frame.
- Frame period: TCONVST_CYCLES + TCONV_CYCLES + 24*CLK_DIV + 1 cycles.
- Config word for channel c, 6 bits MSB first: {1 (S/D single-ended), c[0] (O/S), c[2:1] (S1,S0), UNI, 0 (SLP)}.
- Pipeline: the word sent in frame N selects the conversion read in frame N+1. data_ch is therefore the channel sent in the previous frame.
- First frame after leaving IDLE (or after reset): the result is a dummy and data_valid is not asserted.
- Channel pointer: advances after each SHIFT. Wraps CH_NUM-1 -> 0. Holds its value through IDLE.
  - Re-enable restarts from the held pointer, again with a dummy first frame.
- data_valid: asserted for 1 cycle in the GAP state, except on the dummy frame.
  - data and data_ch update in that same cycle and hold until the next valid.
- busy=1 in every state except IDLE.
- enable is sampled only in IDLE and GAP.

Test Plan:
- Reset: assert rst mid-SHIFT with CLK_DIV=2 -> all outputs 0 in the same cycle; after release, busy=0 while enable=0.
- Config words: CH_NUM=4, UNI=1, enable held -> adc_sdi words are 0x22, 0x32, 0x26, 0x36, 0x22; first frame has no data_valid; later data_ch sequence is 0,1,2,3,0.
- Data capture: the ltc2308 model returns 12'hA5C then 12'h123 -> data=12'hA5C, then 12'h123, each with a single-cycle data_valid.
- Timing: CLK_DIV=2, TCONVST_CYCLES=2, TCONV_CYCLES=80 -> adc_convst high exactly 2 cycles; adc_sck low throughout CONV; 12 rising edges per frame, each 2 cycles high / 2 low; convst-to-convst interval 131 cycles.
- Enable drop mid-SHIFT -> frame completes, data_valid issued, then IDLE with busy=0; re-enable -> dummy frame first, scan resumes at the next pointer channel.
- CH_NUM=1 -> every word is 0x22; every valid after the first frame has data_ch=0.
